// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter/sequencer sharing one serial FP32 adder among NUM_REQ
// requesters. One (a, b) pair is accepted, pushed through the adder's
// a/b/z strobe-ack handshakes, and the sum is returned to the granted
// requester only. Exactly one operation is in flight at a time.
module fp_add_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [31:0]           resp_z,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic [31:0]           add_a,
    output logic                  add_a_stb,
    input  logic                  add_a_ack,
    output logic [31:0]           add_b,
    output logic                  add_b_stb,
    input  logic                  add_b_ack,
    input  logic [31:0]           add_z,
    input  logic                  add_z_stb,
    output logic                  add_z_ack,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT_Z,
        RESP
    } state_t;

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NUM_REQ);

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gsel;
    logic           found;
    logic [IDW:0]   cand;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;
    logic           accept;
    logic           z_done;
    logic           resp_done;
    logic [IDW-1:0] ptr_next;

    // Round-robin search: first valid requester starting at ptr, wrapping.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found = 1'b1;
                gsel  = cand[IDW-1:0];
            end
        end
    end

    // Operand mux for the candidate requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gsel == IDW'(i)) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs. The adder strobes are decoded
    // straight from the state so they can never be high simultaneously.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        add_a_stb  = 1'b0;
        add_b_stb  = 1'b0;
        add_z_ack  = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        z_done     = 1'b0;
        resp_done  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (!rst && found) begin
                    req_ready[gsel] = 1'b1;
                    accept          = 1'b1;
                    state_next      = SEND_A;
                end
            end
            SEND_A: begin
                add_a_stb = 1'b1;
                if (add_a_ack) begin
                    state_next = SEND_B;
                end
            end
            SEND_B: begin
                add_b_stb = 1'b1;
                if (add_b_ack) begin
                    state_next = WAIT_Z;
                end
            end
            WAIT_Z: begin
                add_z_ack = 1'b1;
                if (add_z_stb) begin
                    z_done     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready[grant_id]) begin
                    resp_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ptr_next = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Operand/result capture, grant bookkeeping and the registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_a      <= '0;
            add_b      <= '0;
            grant_id   <= '0;
            ptr        <= '0;
            resp_z     <= '0;
            resp_valid <= '0;
        end else begin
            if (accept) begin
                add_a    <= sel_a;
                add_b    <= sel_b;
                grant_id <= gsel;
            end
            if (z_done) begin
                resp_z               <= add_z;
                resp_valid[grant_id] <= 1'b1;
            end
            if (resp_done) begin
                resp_valid <= '0;
                ptr        <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a behavioural serial-adder model
// answering from a table of hand-computed FP32 sums.
module tb_fp_add_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic [3:0]   req_ready;
    logic [3:0]   resp_valid;
    logic [31:0]  resp_z;
    logic [3:0]   resp_ready = '0;
    logic [31:0]  add_a;
    logic         add_a_stb;
    logic         add_a_ack;
    logic [31:0]  add_b;
    logic         add_b_stb;
    logic         add_b_ack;
    logic [31:0]  add_z;
    logic         add_z_stb;
    logic         add_z_ack;
    logic         busy;
    logic [1:0]   grant_id;

    int checks = 0;
    int errors = 0;

    fp_add_arbiter #(.NUM_REQ(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_z(resp_z), .resp_ready(resp_ready),
        .add_a(add_a), .add_a_stb(add_a_stb), .add_a_ack(add_a_ack),
        .add_b(add_b), .add_b_stb(add_b_stb), .add_b_ack(add_b_ack),
        .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // ---------------- serial adder model ----------------
    typedef enum logic [1:0] {M_GET_A, M_GET_B, M_CALC, M_PUT} mstate_t;
    mstate_t     m_state;
    logic [31:0] m_a, m_b, m_z;
    logic [2:0]  m_cnt;

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            {32'h3F800000, 32'hBF800000}: return 32'h00000000;
            {32'h7FC00000, 32'h3F800000}: return 32'hFFC00000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    assign add_a_ack = (m_state == M_GET_A);
    assign add_b_ack = (m_state == M_GET_B);
    assign add_z_stb = (m_state == M_PUT);
    assign add_z     = m_z;

    always @(posedge clk) begin
        if (rst) begin
            m_state <= M_GET_A;
            m_a <= '0; m_b <= '0; m_z <= '0; m_cnt <= '0;
        end else begin
            case (m_state)
                M_GET_A: if (add_a_stb) begin m_a <= add_a; m_state <= M_GET_B; end
                M_GET_B: if (add_b_stb) begin m_b <= add_b; m_cnt <= 3'd3; m_state <= M_CALC; end
                M_CALC: begin
                    if (m_cnt == 0) begin m_z <= fadd(m_a, m_b); m_state <= M_PUT; end
                    else m_cnt <= m_cnt - 1'b1;
                end
                M_PUT: if (add_z_ack) m_state <= M_GET_A;
                default: m_state <= M_GET_A;
            endcase
        end
    end

    // ---------------- check helper ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- protocol checks every cycle ----------------
    logic        p_a_stb = 1'b0, p_b_stb = 1'b0;
    logic [31:0] p_a = '0, p_b = '0;
    always @(negedge clk) begin
        check("proto_one_hs", 32'(int'(add_a_stb) + int'(add_b_stb) + int'(add_z_ack) <= 1), 1);
        check("proto_resp_onehot0", 32'($onehot0(resp_valid)), 1);
        if (p_a_stb && add_a_stb) check("proto_a_stable", add_a, p_a);
        if (p_b_stb && add_b_stb) check("proto_b_stable", add_b, p_b);
        p_a_stb = add_a_stb; p_b_stb = add_b_stb;
        p_a = add_a; p_b = add_b;
    end

    task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    // Called at a falling edge with the arbiter idle; returns at the falling
    // edge where the response is first presented.
    task automatic txn(input string tag, input logic [3:0] exp_oh, input logic [1:0] exp_g,
                       input logic [31:0] exp_a, input logic [31:0] exp_z);
        int n;
        #1;
        check({tag, "_req_ready"}, 32'(req_ready), 32'(exp_oh));
        @(negedge clk);
        check({tag, "_busy"}, 32'(busy), 1);
        check({tag, "_ready_off"}, 32'(req_ready), 0);
        check({tag, "_add_a"}, add_a, exp_a);
        check({tag, "_a_stb"}, 32'(add_a_stb), 1);
        n = 0;
        while (resp_valid == 4'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_resp_seen"}, 32'(resp_valid != 4'b0), 1);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'(exp_oh));
        check({tag, "_resp_z"}, resp_z, exp_z);
        check({tag, "_grant_id"}, 32'(grant_id), 32'(exp_g));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 0);
        check({tag, "_resp_z"}, resp_z, 0);
        check({tag, "_stbs"}, {29'b0, add_a_stb, add_b_stb, add_z_ack}, 0);
        check({tag, "_add_a"}, add_a, 0);
        check({tag, "_add_b"}, add_b, 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_grant_id"}, 32'(grant_id), 0);
    endtask

    // Hard stop if something hangs beyond every bounded wait.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // ---- reset ----
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);

        // ---- 1: single request from requester 2 ----
        set_slot(2, 32'h3F800000, 32'h40000000);
        req_valid  = 4'b0100;
        resp_ready = 4'b0100;
        #1;
        check("t1_pre_ready", 32'(req_ready), 32'(4'b0100));
        @(negedge clk);
        req_valid = 4'b0000;
        // accepted on that edge; arbiter now in SEND_A, run the remaining checks
        check("t1_busy", 32'(busy), 1);
        check("t1_add_b", add_b, 32'h40000000);
        n = 0;
        while (resp_valid == 4'b0 && n < 60) begin @(negedge clk); n++; end
        check("t1_resp_valid", 32'(resp_valid), 32'(4'b0100));
        check("t1_resp_z", resp_z, 32'h40400000);
        check("t1_grant_id", 32'(grant_id), 2);
        @(negedge clk);
        check("t1_busy_low", 32'(busy), 0);
        check("t1_resp_cleared", 32'(resp_valid), 0);
        check("t1_grant_kept", 32'(grant_id), 2);

        // ---- 3: backpressure (ptr is 3 now; only requester 0 valid) ----
        set_slot(0, 32'h3F800000, 32'h3F800000);
        req_valid  = 4'b0001;
        resp_ready = 4'b0000;
        txn("t3", 4'b0001, 2'd0, 32'h3F800000, 32'h40000000);
        set_slot(1, 32'h3F800000, 32'h40000000);
        set_slot(2, 32'h40000000, 32'h40000000);
        set_slot(3, 32'h3F800000, 32'hBF800000);
        req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            if (c == 5) resp_ready = 4'b1110;
            @(negedge clk);
            check("t3_hold_valid", 32'(resp_valid), 32'(4'b0001));
            check("t3_hold_z", resp_z, 32'h40000000);
            check("t3_no_ready", 32'(req_ready), 0);
            check("t3_no_stb", {30'b0, add_a_stb, add_b_stb}, 0);
        end
        resp_ready = 4'b0001;
        req_valid  = 4'b0000;
        @(negedge clk);
        check("t3_released", 32'(resp_valid), 0);
        check("t3_idle", 32'(busy), 0);

        // ---- 4: arithmetic passthrough (ptr is 1) ----
        resp_ready = 4'b1111;
        set_slot(0, 32'h3F800000, 32'hBF800000);
        req_valid = 4'b0001;
        txn("t4_zero", 4'b0001, 2'd0, 32'h3F800000, 32'h00000000);
        req_valid = 4'b0000;
        @(negedge clk);
        set_slot(3, 32'h7FC00000, 32'h3F800000);
        req_valid = 4'b1000;
        txn("t4_nan", 4'b1000, 2'd3, 32'h7FC00000, 32'hFFC00000);
        req_valid = 4'b0000;
        @(negedge clk);

        // ---- 2: fairness from reset ----
        set_slot(0, 32'h3F800000, 32'h3F800000);
        set_slot(1, 32'h3F800000, 32'h40000000);
        set_slot(2, 32'h40000000, 32'h40000000);
        set_slot(3, 32'h3F800000, 32'hBF800000);
        rst = 1'b1;
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        repeat (2) @(negedge clk);
        check("t2_rst_ready_gated", 32'(req_ready), 0);
        check("t2_rst_grant", 32'(grant_id), 0);
        rst = 1'b0;
        txn("t2_g0", 4'b0001, 2'd0, 32'h3F800000, 32'h40000000); @(negedge clk);
        txn("t2_g1", 4'b0010, 2'd1, 32'h3F800000, 32'h40400000); @(negedge clk);
        txn("t2_g2", 4'b0100, 2'd2, 32'h40000000, 32'h40800000); @(negedge clk);
        txn("t2_g3", 4'b1000, 2'd3, 32'h3F800000, 32'h00000000); @(negedge clk);
        txn("t2_g0b", 4'b0001, 2'd0, 32'h3F800000, 32'h40000000); @(negedge clk);
        txn("t2_g1b", 4'b0010, 2'd1, 32'h3F800000, 32'h40400000);
        req_valid = 4'b1010;
        @(negedge clk);
        txn("t2_g3c", 4'b1000, 2'd3, 32'h3F800000, 32'h00000000); @(negedge clk);
        txn("t2_g1c", 4'b0010, 2'd1, 32'h3F800000, 32'h40400000);
        req_valid = 4'b0000;
        @(negedge clk);

        // ---- 5: reset during WAIT_Z ----
        req_valid = 4'b0100;
        #1;
        check("t5_ready", 32'(req_ready), 32'(4'b0100));
        @(negedge clk);
        req_valid = 4'b0000;
        n = 0;
        while (!add_z_ack && n < 20) begin @(negedge clk); n++; end
        check("t5_in_wait_z", 32'(add_z_ack), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("t5_rst");
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("t5_no_resp", 32'(resp_valid), 0);
        end
        set_slot(0, 32'h3F800000, 32'h3F800000);
        req_valid = 4'b0001;
        txn("t5_after", 4'b0001, 2'd0, 32'h3F800000, 32'h40000000);
        req_valid = 4'b0000;
        @(negedge clk);
        check("t5_done_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
Round-robin arbiter and sequencer that shares one serial FP32 adder between NUM_REQ requesters in the attention_score datapath. It accepts one (a, b) operand pair per transaction from the granted requester, drives the adder's strobe/ack handshakes for a, then b, then z. It returns the sum to that requester only. The adder is non-pipelined, so exactly one operation is in flight at any time.

Parameters:
NUM_REQ, 4, number of requesters (≥2)
IDW, $clog2(NUM_REQ), width of requester index

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high; also tied to the adder's rst
req_valid  in  NUM_REQ  per-requester operand valid
req_a  in  NUM_REQ*32  packed operand a, requester i at [32*i+31:32*i]
req_b  in  NUM_REQ*32  packed operand b, same packing
req_ready  out  NUM_REQ  one-hot accept, combinational
resp_valid  out  NUM_REQ  one-hot result valid, registered
resp_z  out  32  result, shared bus, registered
resp_ready  in  NUM_REQ  per-requester result accept
add_a  out  32  adder input_a
add_a_stb  out  1  adder input_a_stb
add_a_ack  in  1  adder input_a_ack
add_b  out  32  adder input_b
add_b_stb  out  1  adder input_b_stb
add_b_ack  in  1  adder input_b_ack
add_z  in  32  adder output_z
add_z_stb  in  1  adder output_z_stb
add_z_ack  out  1  adder output_z_ack
busy  out  1  high in any state except IDLE
grant_id  out  IDW  index of current or last granted requester

Behaviour:
- Reset values:
  - state=IDLE, ptr=0, grant_id=0.
  - resp_valid=0, resp_z=0.
  - add_a_stb=add_b_stb=add_z_ack=0, add_a=add_b=0.
  - busy=0, req_ready=0.
- Reset mid-operation: the arbiter returns to IDLE next cycle. No response is issued and the in-flight request is dropped. Because the adder shares the same rst, it also restarts in get_a.
- FSM states: IDLE -> SEND_A -> SEND_B -> WAIT_Z -> RESP -> IDLE.
- IDLE:
  - g = first i with req_valid[i] set, searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally, only in IDLE and only when req_valid[g]=1. All other req_ready bits are 0.
  - On the transfer cycle: latch add_a<=req_a[g], add_b<=req_b[g], grant_id<=g, add_a_stb<=1, state<=SEND_A.
- SEND_A:
  - add_a_stb held high and add_a held stable.
  - When add_a_stb && add_a_ack: add_a_stb<=0, add_b_stb<=1, state<=SEND_B.
- SEND_B:
  - Same rule using add_b_ack.
  - On transfer: add_b_stb<=0, add_z_ack<=1, state<=WAIT_Z.
- WAIT_Z:
  - add_z_ack held high.
  - When add_z_stb && add_z_ack: resp_z<=add_z, add_z_ack<=0, resp_valid[grant_id]<=1, state<=RESP.
- RESP:
  - resp_valid and resp_z held stable until resp_ready[grant_id]=1.
  - On that cycle: resp_valid<=0, ptr<=(grant_id+1) mod NUM_REQ, state<=IDLE.
  - resp_ready bits of non-granted requesters are ignored.
- Throughput: no new request is accepted until RESP completes. The earliest next req_ready is the cycle after the resp handshake.
- Arbiter overhead: 1 accept cycle + 1 cycle per handshake beyond the adder's own latency.
- Fairness: a requester holding req_valid continuously is granted within NUM_REQ transactions.
- Valid/ready rules:
  - Requesters must hold req_a/req_b stable while req_valid=1 and not accepted.
  - Deasserting req_valid before acceptance is legal; nothing is latched.
- The arbiter never asserts more than one of add_a_stb, add_b_stb, add_z_ack at a time.
- The arbiter performs no arithmetic; resp_z is bit-exact with add_z.

Test Plan:
1. Single request: req_valid=4'b0100, a=0x3F800000, b=0x40000000 -> req_ready=4'b0100 for one cycle; resp_valid=4'b0100, resp_z=0x40400000, grant_id=2; busy falls after the resp handshake.
2. Fairness: all four req_valid held high from reset, resp_ready=4'b1111 -> grants in order 0,1,2,3,0,1. With only req 1 and req 3 valid after grant 1 -> next grant 3, then 1.
3. Backpressure: resp_ready low for 10 cycles in RESP -> resp_valid and resp_z stable, req_ready=0 throughout, no new adder strobes.
4. Arithmetic passthrough: a=0x3F800000, b=0xBF800000 -> resp_z=0x00000000. a=0x7FC00000, b=0x3F800000 -> resp_z=0xFFC00000.
5. Reset mid-operation: assert rst for 1 cycle in WAIT_Z -> next cycle all outputs at reset values and no resp_valid. A subsequent request from req 0 (1.0+1.0) returns 0x40000000 with grant_id=0.
6. Protocol checks (assertions on every test): add_a/add_b stable while their strobe is high; at most one of the three handshake signals high; resp_valid one-hot or zero.
